// File: rtl/uart_tx_fsm_if.sv
// uart_tx_fsm_if: byte handshake into the UART transmitter plus its serial-line outputs.
// master = byte producer, slave = transmitter.
interface uart_tx_fsm_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       ready;
    logic       tx;
    logic       tx_done;

    modport master (
        output data_in,
        output data_valid,
        input  ready,
        input  tx,
        input  tx_done
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output ready,
        output tx,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: 8N1/8N2 UART transmitter with a valid/ready byte handshake.
// Optional even parity bit between data and stop: define UART_TX_PARITY_EN.
// The line is driven straight from a flop, so tx never glitches.
// ready is also high in the last stop cycle. A byte held on data_valid is then taken
// on the edge that ends the frame, and its start bit follows the stop bit directly.
module uart_tx_fsm #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_tx_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop_idx_q, stop_idx_d;
    logic [7:0]  shift_q;
    logic        tx_q, tx_d;
    logic        rdy_en_q;
    logic        baud_last;
    logic        frame_end;
    logic        ready;
    logic        accept;

    assign baud_last = (baud_q == BAUD_LAST);
    assign frame_end = (state_q == STOP) && baud_last && (stop_idx_q == STOP_LAST);
    assign accept    = bus.data_valid && ready;

    // State register: FSM state, bit timing counters and the registered line output.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            rdy_en_q   <= 1'b1;
        end
    end

    // Byte holding register, loaded only on acceptance so later data_in changes are ignored.
    // NOTE: this register is reset so the line never shows undefined data after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else if (accept) begin
            shift_q <= bus.data_in;
        end
    end

    // Next-state logic: advance one bit whenever the baud counter wraps.
    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + 16'd1;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (accept) begin
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d   = DATA;
                    baud_d    = '0;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    state_d = STOP;
                    baud_d  = '0;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (stop_idx_q == STOP_LAST) begin
                        state_d    = accept ? START : IDLE;
                        stop_idx_d = 1'b0;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Output logic: line level for the upcoming state, plus the handshake and done strobes.
    always_comb begin
        tx_d  = 1'b1;
        ready = rdy_en_q && ((state_q == IDLE) || frame_end);
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = shift_q[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = ^shift_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign bus.tx      = tx_q;
    assign bus.ready   = ready;
    assign bus.tx_done = frame_end;

endmodule

// File: doc/uart_tx_fsm.md
UART_TX_FSM -- requirements
Module: uart_tx_fsm

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 The module SHALL have parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-003 The module SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port data_in, input, 8 bits: byte to transmit.
REQ-006 The module SHALL have port data_valid, input, 1 bit: transmit request, qualified by ready.
REQ-007 The module SHALL have port ready, output, 1 bit: high when a new byte can be accepted.
REQ-008 The module SHALL have port tx, output, 1 bit: UART serial line, idle high.
REQ-009 The module SHALL have port tx_done, output, 1 bit: one-cycle pulse at the end of the last stop bit.

Function
REQ-010 The FSM SHALL have exactly these states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
REQ-011 Acceptance SHALL occur on a rising edge with data_valid=1 and ready=1; data_in is latched into an internal shift register on that edge.
REQ-012 data_valid asserted while ready=0 SHALL be ignored; no byte is queued.
REQ-013 On acceptance the FSM SHALL leave IDLE for START; tx=0 and ready=0 from the next cycle.
REQ-014 Each bit (start, data, parity, stop) SHALL hold tx for exactly CLKS_PER_BIT cycles, timed by a baud counter that resets on every bit boundary.
REQ-015 DATA SHALL emit 8 bits LSB first, tracked by a 3-bit index; DATA exits after index 7 has completed.
REQ-016 STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-017 On the last cycle of STOP, tx_done SHALL be 1; on the next edge the FSM enters IDLE and ready=1.
REQ-018 Frame length from acceptance edge to the ready rising edge SHALL be (1+8+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with the macro and 0 without it.
REQ-019 Back-to-back: data_valid held high SHALL be accepted on the first cycle ready=1, giving no idle-high gap beyond the stop bits.
REQ-020 tx SHALL be driven from a register (glitch-free); no combinational path from data_in to tx.
REQ-021 Changes to data_in after acceptance SHALL NOT affect the frame in flight.

Reset
REQ-022 Asserting rst_n=0 SHALL immediately set tx=1, ready=0, tx_done=0, state=IDLE, and clear all counters, including in the middle of a frame.
REQ-023 ready SHALL rise on the first rising edge after rst_n deasserts; no byte is accepted before that edge.

Configuration
REQ-024 With macro UART_TX_PARITY_EN defined, a PARITY state SHALL follow DATA and transmit even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-025 With UART_TX_PARITY_EN undefined, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Verification
REQ-026 CLKS_PER_BIT=4, no macro, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit; tx_done pulses at cycle 40; ready rises at cycle 40.
REQ-027 UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1; frame is 44 cycles at CLKS_PER_BIT=4.
REQ-028 data_valid held high with 0x55 then 0xAA -> the second start bit begins on the cycle after the first frame's tx_done, with no extra idle-high cycles.
REQ-029 Pulse data_valid with 0xFF mid-frame while ready=0 -> the byte is ignored; only the original frame is sent; ready returns high once.
REQ-030 Assert rst_n low during DATA bit 3 -> tx=1 the same cycle; after release, ready=1 on the next edge; a new byte 0x3C transmits correctly.
REQ-031 STOP_BITS=2, CLKS_PER_BIT=4 -> stop phase lasts 8 cycles; total frame is 44 cycles without the macro.
